uart_tx_buffer: RTL and testbench



---
 rtl/uart_tx_buffer_if.sv | 38 +++
 rtl/uart_tx_buffer.sv | 151 +++++++++++++++
 tb/tb_uart_tx_buffer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffer_if.sv
// Application-side bus of uart_tx_buffer: write handshake, FIFO status and transmitter hand-off.
// Optional overflow flag/clear signals exist only when UART_TX_BUF_OVF_EN is defined.
interface uart_tx_buffer_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              busy;
  logic              tx_start;
  logic [7:0]        tx_din;
`ifdef UART_TX_BUF_OVF_EN
  logic              ovf;
  logic              ovf_clr;

  modport master (
    output wr_en, wr_data, ovf_clr,
    input  full, empty, level, busy, tx_start, tx_din, ovf
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr,
    output full, empty, level, busy, tx_start, tx_din, ovf
  );
`else
  modport master (
    output wr_en, wr_data,
    input  full, empty, level, busy, tx_start, tx_din
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, level, busy, tx_start, tx_din
  );
`endif
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus frame pacer feeding a UART transmitter that has no done flag.
// Optional sticky overflow flag enabled by defining UART_TX_BUF_OVF_EN.
module uart_tx_buffer #(
  parameter int ADDR_W      = 4,
  parameter int DBIT        = 8,
  parameter int SB_TICK     = 16,
  parameter int GUARD_TICKS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_tick,
  uart_tx_buffer_if.slave bus
);

  localparam int DEPTH       = 1 << ADDR_W;
  localparam int FRAME_TICKS = 16 * (1 + DBIT) + SB_TICK;
  localparam int WAIT_TICKS  = FRAME_TICKS + GUARD_TICKS;
  localparam int CNT_W       = $clog2(WAIT_TICKS + 1);

  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_TICKS - 1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_full;
  logic              r_empty;
  logic              r_busy;
  logic              r_tx_start;
  logic [7:0]        r_tx_din;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_wr_acc;
  logic              w_pop;
  logic              w_tick_cnt;
  logic              w_frame_done;
  logic              w_in_frame_nxt;
  logic [ADDR_W:0]   w_level_nxt;

  // full is the registered pre-edge status, so a write in the pop cycle of a full FIFO is dropped.
  assign w_wr_acc       = bus.wr_en & ~r_full;
  assign w_pop          = (r_state == IDLE) & ~r_empty;
  assign w_tick_cnt     = (r_state == WAIT) & s_tick & ~r_tx_start;
  assign w_frame_done   = w_tick_cnt & (r_cnt == CNT_LAST);
  assign w_in_frame_nxt = w_pop | ((r_state == WAIT) & ~w_frame_done);

  always_comb begin
    // NOTE: default first so every path assigns w_level_nxt and no latch is inferred.
    w_level_nxt = r_level;
    if (w_wr_acc && !w_pop) begin
      w_level_nxt = r_level + LVL_ONE;
    end else if (!w_wr_acc && w_pop) begin
      w_level_nxt = r_level - LVL_ONE;
    end
  end

  // NOTE: storage has no reset; only pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every edge sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      r_empty <= (w_level_nxt == '0);
      r_busy  <= w_in_frame_nxt | (w_level_nxt != '0);
    end
  end

  // Frame pacer: the counter meters one frame plus guard ticks after each start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rd_ptr   <= '0;
      r_tx_start <= 1'b0;
      r_tx_din   <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_start <= 1'b1;
            r_tx_din   <= r_mem[r_rd_ptr];
            r_rd_ptr   <= r_rd_ptr + PTR_ONE;
            r_cnt      <= '0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (w_tick_cnt) begin
            if (w_frame_done) begin
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_BUF_OVF_EN
  logic r_ovf;

  // A dropped write outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (bus.wr_en && r_full) begin
      r_ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.full     = r_full;
  assign bus.empty    = r_empty;
  assign bus.level    = r_level;
  assign bus.busy     = r_busy;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_din   = r_tx_din;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized bench for uart_tx_buffer against a queue-based model of the buffer and frame pacing.
module tb_uart_tx_buffer;

  localparam int ADDR_W      = 4;
  localparam int DEPTH       = 1 << ADDR_W;
  localparam int DBIT        = 8;
  localparam int SB_TICK     = 16;
  localparam int GUARD_TICKS = 1;
  localparam int WAIT_TICKS  = 16 * (1 + DBIT) + SB_TICK + GUARD_TICKS;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic s_tick = 1'b0;

  uart_tx_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_buffer #(
    .ADDR_W(ADDR_W), .DBIT(DBIT), .SB_TICK(SB_TICK), .GUARD_TICKS(GUARD_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of pending bytes, ticks counted since the last start pulse.
  logic [7:0] q[$];
  int         ticks;
  bit         in_frame;
  bit         m_start;
  bit         m_ovf;
  logic [7:0] m_din;
  bit         last_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ticks    = 0;
    in_frame = 0;
    m_start  = 0;
    m_ovf    = 0;
    m_din    = 8'h00;
  endtask

  task automatic model_update(input logic we, input logic [7:0] wd, input logic tk, input logic clr);
    bit pre_full;
    bit prev_start;
    pre_full   = (q.size() == DEPTH);
    prev_start = m_start;
    if (we && pre_full)  m_ovf = 1;
    else if (clr)        m_ovf = 0;
    m_start = 0;
    if (!in_frame && q.size() > 0) begin
      m_start  = 1;
      m_din    = q.pop_front();
      in_frame = 1;
      ticks    = 0;
    end else if (in_frame && tk && !prev_start) begin
      ticks++;
      if (ticks == WAIT_TICKS) in_frame = 0;
    end
    if (we && !pre_full) q.push_back(wd);
  endtask

  task automatic compare_all();
    check("tx_start", bus.tx_start, m_start);
    check("tx_din",   bus.tx_din,   m_din);
    check("level",    bus.level,    q.size());
    check("full",     bus.full,     q.size() == DEPTH);
    check("empty",    bus.empty,    q.size() == 0);
    check("busy",     bus.busy,     in_frame || q.size() != 0 || m_start);
`ifdef UART_TX_BUF_OVF_EN
    check("ovf",      bus.ovf,      m_ovf);
`endif
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_tx_start"}, bus.tx_start, 0);
    check({pfx, "_tx_din"},   bus.tx_din,   8'h00);
    check({pfx, "_level"},    bus.level,    0);
    check({pfx, "_full"},     bus.full,     0);
    check({pfx, "_empty"},    bus.empty,    1);
    check({pfx, "_busy"},     bus.busy,     0);
`ifdef UART_TX_BUF_OVF_EN
    check({pfx, "_ovf"},      bus.ovf,      0);
`endif
  endtask

  function automatic logic next_tick();
    logic t;
    t = last_tick ? 1'b0 : ($urandom_range(0, 3) != 0);
    last_tick = t;
    return t;
  endfunction

  // Called at a falling edge: drive inputs, advance the model, check after the next rising edge.
  task automatic step(input logic we, input logic [7:0] wd, input logic tk, input logic clr);
    bus.wr_en   = we;
    bus.wr_data = wd;
    s_tick      = tk;
`ifdef UART_TX_BUF_OVF_EN
    bus.ovf_clr = clr;
`endif
    model_update(we, wd, tk, clr);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (in_frame || q.size() != 0); i++) begin
      step(1'b0, 8'h00, next_tick(), 1'b0);
    end
    step(1'b0, 8'h00, next_tick(), 1'b0);
    check("drain_done", bus.busy, 0);
  endtask

  initial begin
    int written;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
`ifdef UART_TX_BUF_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    last_tick = 0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Single byte: latency and full frame length.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    drain(2000);

    // Short burst, back-to-back frames.
    for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), next_tick(), 1'b0);
    drain(4000);

    // Hold the pacer in WAIT (no ticks) and overfill the FIFO.
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    check("fill_level", bus.level, DEPTH);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    // Keep writing through the pop cycle: dropped there, accepted right after.
    for (int i = 0; i < 2000 && in_frame; i++) step(1'b1, 8'h40, next_tick(), 1'b0);
    step(1'b1, 8'h41, next_tick(), 1'b0);
    step(1'b1, 8'h42, next_tick(), 1'b0);
    check("refill_level", bus.level, DEPTH);
    drain(20000);

    // Reset mid-frame with five bytes queued.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 2000 && !(in_frame && ticks == 80); i++)
      step(1'b0, 8'h00, next_tick(), 1'b0);
    check("mid_ticks", ticks, 80);
    bus.wr_en = 1'b0;
    s_tick    = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) step(1'b0, 8'h00, next_tick(), 1'b0);

    // Random writes over time; pointers wrap repeatedly.
    written = 0;
    for (int i = 0; i < 5000 && written < 20; i++) begin
      logic we;
      we = ($urandom_range(0, 39) == 0);
      if (we) written++;
      step(we, 8'($urandom), next_tick(), $urandom_range(0, 20) == 0);
    end
    check("rand_written", written, 20);
    drain(20000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
